// File: rtl/od_line_pkg.sv
// Shared definitions for the single-wire open-drain line: FSM states,
// default pulse timing and the pulse-width classifier used by both ends.
package od_line_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOW       = 2'd1,
    WAIT_HIGH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PULSE_GLITCH = 2'd0,
    PULSE_ONE    = 2'd1,
    PULSE_ZERO   = 2'd2,
    PULSE_RESET  = 2'd3
  } pulse_kind_t;

  localparam int DEF_BIT_MIN    = 2;
  localparam int DEF_BIT_THRESH = 8;
  localparam int DEF_RST_WIDTH  = 32;

  // A low pulse of 'width' cycles means: glitch below bit_min, a 1 below
  // bit_thresh, a 0 below rst_width, and a bus reset from rst_width upward.
  function automatic pulse_kind_t classify_width(input int width,
                                                 input int bit_min,
                                                 input int bit_thresh,
                                                 input int rst_width);
    pulse_kind_t kind;
    if (width >= rst_width) begin
      kind = PULSE_RESET;
    end else if (width < bit_min) begin
      kind = PULSE_GLITCH;
    end else if (width < bit_thresh) begin
      kind = PULSE_ONE;
    end else begin
      kind = PULSE_ZERO;
    end
    return kind;
  endfunction

endpackage

// File: rtl/od_line_pad.sv
// Switch-level model of the shared open-drain line: a weak pull-up holds
// the wire high, any transmitter pulls it low through an nmos switch, and
// a buffer hands the resolved level to the receiver.
module od_line_pad (
  input  logic tx_low,
  output wire  line_in
);

  wire line;

  pullup pu (line);

  nmos pd (line, 1'b0, tx_low);

  buf ob (line_in, line);

endmodule

// File: rtl/od_line_receiver.sv
// Listening end of the open-drain line. Synchronises the raw level, times
// every low pulse, decodes short/long/very-long lows into 1/0/bus reset,
// and packs bits LSB-first into words offered on a valid/ready port.
module od_line_receiver
  import od_line_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int BIT_MIN     = DEF_BIT_MIN,
  parameter int BIT_THRESH  = DEF_BIT_THRESH,
  parameter int RST_WIDTH   = DEF_RST_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              reset_seen,
  output logic              glitch,
  output logic              overrun
);

  localparam int CNT_W     = $clog2(RST_WIDTH + 1);
  localparam int BIT_CNT_W = $clog2(DATA_W + 1);
  localparam int WARM_W    = $clog2(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_RESET   = CNT_W'(RST_WIDTH);
  localparam logic [BIT_CNT_W-1:0] BIT_ONE     = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST    = BIT_CNT_W'(DATA_W - 1);
  localparam logic [WARM_W-1:0]    WARM_ONE    = WARM_W'(1);
  localparam logic [WARM_W-1:0]    WARM_DONE   = WARM_W'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [WARM_W-1:0]      warm_q;
  logic                   seen_high_q;
  logic                   s;
  logic                   s_valid;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;

  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [DATA_W-1:0]      shift_q;
  logic [DATA_W-1:0]      word_next;

  logic                   bit_en;
  logic                   bit_val;
  logic                   glitch_ev;
  logic                   reset_ev;
  logic                   word_done;
  logic                   slot_free;
  logic                   handshake;

  assign s       = sync_q[SYNC_STAGES-1];
  assign s_valid = (warm_q == WARM_DONE);

  // Synchroniser chain; reset to the idle-high level so a released line
  // never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
    end
  end

  // Track when the chain holds real samples and whether the line has been
  // high since reset, so a line already low at release is not decoded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_q      <= '0;
      seen_high_q <= 1'b0;
    end else begin
      if (!s_valid) begin
        warm_q <= warm_q + WARM_ONE;
      end
      if (s_valid && s) begin
        seen_high_q <= 1'b1;
      end
    end
  end

  // FSM state and low-width counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, width counting and pulse classification.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_en    = 1'b0;
    bit_val   = 1'b0;
    glitch_ev = 1'b0;
    reset_ev  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!s) begin
          if (seen_high_q) begin
            state_d = LOW;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = WAIT_HIGH;
          end
        end
      end
      LOW: begin
        if (!s) begin
          if (cnt_q != CNT_RESET) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (cnt_d == CNT_RESET) begin
            reset_ev = 1'b1;
            state_d  = WAIT_HIGH;
            cnt_d    = '0;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          unique case (classify_width(int'(cnt_q), BIT_MIN, BIT_THRESH, RST_WIDTH))
            PULSE_GLITCH: glitch_ev = 1'b1;
            PULSE_ONE: begin
              bit_en  = 1'b1;
              bit_val = 1'b1;
            end
            PULSE_ZERO: begin
              bit_en  = 1'b1;
              bit_val = 1'b0;
            end
            default: begin
              bit_en = 1'b0;
            end
          endcase
        end
      end
      WAIT_HIGH: begin
        if (s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // New bits enter at the top and move down, so the first bit ends at [0].
  assign word_next = {bit_val, shift_q[DATA_W-1:1]};
  assign word_done = bit_en && (bit_cnt_q == BIT_LAST);
  assign handshake = data_valid && data_ready;
  assign slot_free = !data_valid || data_ready;

  // Shift register and bit counter; a bus reset throws away partial words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (reset_ev) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (bit_en) begin
      if (word_done) begin
        shift_q   <= '0;
        bit_cnt_q <= '0;
      end else begin
        shift_q   <= word_next;
        bit_cnt_q <= bit_cnt_q + BIT_ONE;
      end
    end
  end

  // Output slot and event pulses; a held word is never overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      reset_seen <= 1'b0;
      glitch     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      reset_seen <= reset_ev;
      glitch     <= glitch_ev;
      overrun    <= word_done && !slot_free;
      if (word_done && slot_free) begin
        data_out   <= word_next;
        data_valid <= 1'b1;
      end else if (handshake) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
